// File: rtl/serial_a_paralelo.sv
// serial_a_paralelo: receive-side deserializer for the clk32f bit stream.
// It hunts for the COMMA idle byte at any bit offset and aligns the byte
// boundary to it. After LOCK_COUNT aligned commas in a row it locks, and
// from then on it rebuilds bytes and marks each as data or COMMA.
// Optional build macro: S2P_IDLE_COUNT_EN adds a saturating idle_cnt output
// that counts COMMA bytes received while locked.
module serial_a_paralelo #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       byte_stb,
    output logic       active
`ifdef S2P_IDLE_COUNT_EN
    ,
    output logic [7:0] idle_cnt
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    // Lock target as a 4-bit value; legal LOCK_COUNT range is 1..15.
    localparam logic [3:0] LOCK_TARGET = LOCK_COUNT[3:0];

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_bc_cnt;
    logic [7:0] r_out;
    logic       r_out_valid;
    logic       r_byte_stb;
    logic       r_active;

    logic [7:0] w_nxt;
    logic       w_is_comma;
    logic       w_boundary;
    logic [3:0] w_bc_inc;

    // The byte as it will look once the current bit is shifted in.
    assign w_nxt      = {r_sr[6:0], in};
    assign w_is_comma = (w_nxt == COMMA);
    // bit_cnt==7 marks the last bit of an aligned byte once aligned.
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_bc_inc   = r_bc_cnt + 4'd1;

    // Shift register, bit counter, alignment FSM and registered outputs.
    always_ff @(posedge clk32f) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_bc_cnt    <= 4'd0;
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_sr      <= w_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            case (r_state)
                SEARCH: begin
                    // Any bit offset is acceptable; a hit restarts byte framing.
                    if (w_is_comma) begin
                        r_bit_cnt <= 3'd0;
                        r_bc_cnt  <= 4'd1;
                        if (LOCK_TARGET == 4'd1) begin
                            r_state  <= ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    // Only aligned bytes count; one non-comma drops the offset.
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            r_bc_cnt <= w_bc_inc;
                            if (w_bc_inc == LOCK_TARGET) begin
                                r_state  <= ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_state  <= SEARCH;
                            r_bc_cnt <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    // Locked: publish each aligned byte with a one-cycle strobe.
                    if (w_boundary) begin
                        r_out       <= w_nxt;
                        r_out_valid <= !w_is_comma;
                        r_byte_stb  <= 1'b1;
                    end else begin
                        r_byte_stb <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign byte_stb  = r_byte_stb;
    assign active    = r_active;

`ifdef S2P_IDLE_COUNT_EN
    logic [7:0] r_idle_cnt;

    // Count COMMA bytes seen while locked, saturating at 8'hFF.
    always_ff @(posedge clk32f) begin
        if (!reset) begin
            r_idle_cnt <= 8'h00;
        end else if (r_state == ACTIVE && w_boundary && w_is_comma
                     && r_idle_cnt != 8'hFF) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end

    assign idle_cnt = r_idle_cnt;
`endif

endmodule

// File: tb/tb_serial_a_paralelo.sv
// Directed bench for serial_a_paralelo. Expected bytes are queued as they
// are sent while locked and popped when byte_stb is seen.
// With S2P_IDLE_COUNT_EN defined the idle_cnt output is also checked.
module tb_serial_a_paralelo;

    localparam logic [7:0] BC = 8'hBC;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b0;
    logic       in     = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       byte_stb;
    logic       active;
`ifdef S2P_IDLE_COUNT_EN
    logic [7:0] idle_cnt;
    int         exp_idle = 0;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    logic       exp_active = 1'b0;
    logic [7:0] last_out   = 8'h00;
    logic       last_valid = 1'b0;

    serial_a_paralelo dut (
        .clk32f    (clk32f),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .byte_stb  (byte_stb),
        .active    (active)
`ifdef S2P_IDLE_COUNT_EN
        ,
        .idle_cnt  (idle_cnt)
`endif
    );

    always #5 clk32f = ~clk32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, clock it in, then check outputs 1 time unit later.
    task automatic step(input logic b, input logic exp_stb);
        logic [8:0] e;
        in = b;
        @(posedge clk32f);
        #1;
        chk("active", {31'd0, active}, {31'd0, exp_active});
        chk("byte_stb", {31'd0, byte_stb}, {31'd0, exp_stb});
`ifdef S2P_IDLE_COUNT_EN
        chk("idle_cnt", {24'd0, idle_cnt}, exp_idle);
`endif
        if (exp_stb) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL scoreboard: observed strobe, expected empty queue");
            end else begin
                e = exp_q.pop_front();
                chk("out", {24'd0, out}, {24'd0, e[7:0]});
                chk("out_valid", {31'd0, out_valid}, {31'd0, e[8]});
                last_out   = e[7:0];
                last_valid = e[8];
                $display("byte out=%02h valid=%0b", out, out_valid);
            end
        end else begin
            chk("out_hold", {24'd0, out}, {24'd0, last_out});
            chk("valid_hold", {31'd0, out_valid}, {31'd0, last_valid});
        end
    endtask

    // Send a byte MSB first. emit: a strobe is expected on its LSB edge.
    // lock_here: active is expected to rise on its LSB edge.
    task automatic send_byte(input logic [7:0] b, input logic emit, input logic lock_here);
        if (emit) exp_q.push_back({(b != BC), b});
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                if (lock_here) exp_active = 1'b1;
`ifdef S2P_IDLE_COUNT_EN
                if (emit && b == BC && exp_idle < 255) exp_idle++;
`endif
            end
            step(b[i], emit && (i == 0));
        end
    endtask

    // Hold reset for n cycles with random input; everything must read zero.
    task automatic do_reset(input int n);
        reset = 1'b0;
        exp_active = 1'b0;
        last_out   = 8'h00;
        last_valid = 1'b0;
        exp_q.delete();
`ifdef S2P_IDLE_COUNT_EN
        exp_idle = 0;
`endif
        for (int i = 0; i < n; i++) begin
            in = 1'($urandom_range(0, 1));
            @(posedge clk32f);
            #1;
            chk("rst_out", {24'd0, out}, 32'd0);
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_stb", {31'd0, byte_stb}, 32'd0);
            chk("rst_active", {31'd0, active}, 32'd0);
`ifdef S2P_IDLE_COUNT_EN
            chk("rst_idle", {24'd0, idle_cnt}, 32'd0);
`endif
        end
        reset = 1'b1;
        $display("reset applied for %0d cycles", n);
    endtask

    initial begin
        int n_idle;
`ifdef S2P_IDLE_COUNT_EN
        n_idle = 300;
`else
        n_idle = 20;
`endif
        // Reset hold
        do_reset(5);

        // Clean lock after 3 arbitrary bits
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 3; i++) send_byte(BC, 1'b0, 1'b0);
        send_byte(BC, 1'b0, 1'b1);

        // Data after lock
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(BC,    1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);

        // Lock abort: a non-comma in the middle of the run restarts the count
        do_reset(1);
        send_byte(BC,    1'b0, 1'b0);
        send_byte(BC,    1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(BC, 1'b0, 1'b0);
        send_byte(BC, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b0);

        // Reset with A5 half shifted in; relock needed before any strobe
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        do_reset(1);
        for (int i = 0; i < 3; i++) send_byte(BC, 1'b0, 1'b0);
        send_byte(BC, 1'b0, 1'b1);
        send_byte(8'h5A, 1'b1, 1'b0);

        // Long idle run while locked, then a data byte
        for (int i = 0; i < n_idle; i++) send_byte(BC, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b0);
`ifdef S2P_IDLE_COUNT_EN
        chk("idle_sat", {24'd0, idle_cnt}, 32'h0000_00FF);
`endif
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_a_paralelo.md
Name: serial_a_paralelo

Overview:
- Receive-side deserializer that consumes the 1-bit MSB-first stream produced by the transmit parallel-to-serial stage.
- Searches the stream for the idle comma 8'hBC and aligns byte boundaries to it.
- Declares lock after a run of aligned commas, then rebuilds 8-bit bytes with a valid flag.
- Sits directly downstream of the serializer in the clk32f domain; byte/strobe outputs feed the receive unstriping logic.

Parameters:
- COMMA, 8'hBC, idle/alignment byte; on the wire MSB first.
- LOCK_COUNT, 4, consecutive aligned COMMA bytes required to enter ACTIVE; legal range 1..15.

Ports:
- clk32f  input  1  bit clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in  input  1  serial data bit, MSB of each byte first.
- out  output  8  recovered byte.
- out_valid  output  1  1 = out holds a data byte; 0 = out holds COMMA.
- byte_stb  output  1  one-cycle pulse when out/out_valid update.
- active  output  1  1 while byte alignment is locked.

Behaviour:
- Reset (reset==0 at a clk32f edge): state=SEARCH; sr=0; bit_cnt=0; bc_cnt=0; out=8'h00, out_valid=0, byte_stb=0, active=0.
- Shift path, every cycle out of reset: sr <= nxt, where nxt = {sr[6:0], in}. bit_cnt (3 bits) increments every cycle and wraps 7->0.
- Boundary cycle: bit_cnt==7 in LOCKING/ACTIVE. At this cycle nxt holds a complete aligned byte.
- State SEARCH:
  - Each cycle, compare nxt with COMMA at any bit offset.
  - On match: bit_cnt<=0, bc_cnt<=1.
  - If LOCK_COUNT==1, go to ACTIVE and set active<=1; otherwise go to LOCKING.
- State LOCKING, evaluated only on boundary cycles:
  - nxt==COMMA: bc_cnt<=bc_cnt+1. If bc_cnt+1==LOCK_COUNT, go to ACTIVE and set active<=1.
  - nxt!=COMMA: go to SEARCH, bc_cnt<=0. The bit offset is not retained; the next COMMA at any offset restarts the count.
  - Non-boundary cycles: no comparison.
- State ACTIVE:
  - On every boundary cycle: out<=nxt, out_valid<=(nxt!=COMMA), byte_stb<=1.
  - On all other cycles: byte_stb<=0; out and out_valid hold.
  - No outputs are produced before ACTIVE; the lock-completing COMMA itself is not emitted.
  - ACTIVE has no exit except reset.
- Latency: last (LSB) bit of a byte sampled at edge t; out/out_valid/byte_stb valid after edge t (one register stage). Spacing between byte_stb pulses is exactly 8 cycles.
- Reset mid-byte or mid-lock: all state returns to reset values on that edge; any partial byte is discarded.
- active is never asserted combinationally; it changes only on clk32f edges.

Optional Feature:
- Macro: S2P_IDLE_COUNT_EN.
- Defined:
  - Adds output idle_cnt [7:0], reset 0.
  - Increments on every ACTIVE boundary cycle where nxt==COMMA.
  - Saturates at 8'hFF; updated in the same cycle as byte_stb.
- Not defined: no idle_cnt port or logic; behaviour otherwise identical.

Test Plan:
- Reset hold: reset=0 for 5 cycles with random in -> out=00, out_valid=0, byte_stb=0, active=0 every cycle.
- Clean lock: 3 random bits, then 4x BC (MSB first) -> active rises after the edge sampling the 4th BC's LSB; no byte_stb before then.
- Data after lock: BC x4, then 8'hA5, BC, 8'h3C -> byte_stb every 8 cycles; out/out_valid = A5/1, BC/0, 3C/1.
- Lock abort: BC, BC, 8'h00, then BC x4 -> active stays 0 through the 8'h00 byte; asserts only after the 4th BC of the later run.
- Reset mid-stream: ACTIVE with A5 half shifted, reset=0 for 1 cycle -> all outputs 0; relock required (4x BC) before the next byte_stb.
- S2P_IDLE_COUNT_EN build: lock, then 300x BC -> idle_cnt saturates at FF, out_valid=0 throughout; non-macro build compiles without idle_cnt.
